db15_joy_scan: RTL and testbench



---
 rtl/db15_joy_scan.sv | 127 ++++++++++++
 tb/tb_db15_joy_scan.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db15_joy_scan.sv
// rtl/db15_joy_scan.sv - DB15 joystick adapter serial reader with two-frame debounce
module db15_joy_scan #(
   parameter int CLK_DIV   = 24,
   parameter int GAP_TICKS = 2000
) (
   input  logic        clk,
   input  logic        RESET_N,
   input  logic        JOY_DATA,
   output logic        JOY_CLK,
   output logic        JOY_LOAD,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_stb,
   output logic        changed
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

   state_t        state;
   logic [DW-1:0] divcnt;
   logic [GW-1:0] gapcnt;
   logic [4:0]    bitidx;
   logic          phase;
   logic [1:0]    data_sync;
   logic [31:0]   sr;
   logic [31:0]   prev;
   logic [31:0]   cur;
   logic          tick;

   assign tick = (divcnt == DW'(CLK_DIV - 1));
   assign cur  = ~sr;

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         divcnt <= '0;
      end else if (tick) begin
         divcnt <= '0;
      end else begin
         divcnt <= divcnt + DW'(1);
      end
   end

   // Idle level of the adapter line is high, so the synchronizer resets to 1.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         data_sync <= 2'b11;
      end else begin
         data_sync <= {data_sync[0], JOY_DATA};
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= S_IDLE;
         gapcnt    <= '0;
         bitidx    <= '0;
         phase     <= 1'b0;
         sr        <= '1;
         prev      <= '1;
         JOY_CLK   <= 1'b0;
         JOY_LOAD  <= 1'b1;
         joystick1 <= '0;
         joystick2 <= '0;
         frame_stb <= 1'b0;
         changed   <= 1'b0;
      end else begin
         frame_stb <= 1'b0;
         changed   <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (gapcnt == GW'(GAP_TICKS - 1)) begin
                     gapcnt   <= '0;
                     JOY_LOAD <= 1'b0;
                     phase    <= 1'b0;
                     state    <= S_LOAD;
                  end else begin
                     gapcnt <= gapcnt + GW'(1);
                  end
               end
               // phase doubles as the two-tick load counter here
               S_LOAD: begin
                  if (!phase) begin
                     phase <= 1'b1;
                  end else begin
                     JOY_LOAD <= 1'b1;
                     bitidx   <= '0;
                     phase    <= 1'b0;
                     state    <= S_SHIFT;
                  end
               end
               S_SHIFT: begin
                  if (!phase) begin
                     JOY_CLK     <= 1'b0;
                     sr[bitidx]  <= data_sync[1];
                     phase       <= 1'b1;
                  end else begin
                     JOY_CLK <= 1'b1;
                     phase   <= 1'b0;
                     if (bitidx == 5'd31) begin
                        state <= S_LATCH;
                     end else begin
                        bitidx <= bitidx + 5'd1;
                     end
                  end
               end
               S_LATCH: begin
                  JOY_CLK <= 1'b0;
                  if (cur == prev && cur != {joystick2, joystick1}) begin
                     joystick1 <= cur[15:0];
                     joystick2 <= cur[31:16];
                     changed   <= 1'b1;
                  end
                  prev      <= cur;
                  frame_stb <= 1'b1;
                  state     <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_db15_joy_scan.sv
// tb/tb_db15_joy_scan.sv - randomized bench for db15_joy_scan with a 74HC165 chain model
module tb_db15_joy_scan;

   localparam int CD         = 4;
   localparam int GT         = 3;
   localparam int FRAME_CLKS = (GT + 2 + 64 + 1) * CD;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic        JOY_DATA;
   logic        JOY_CLK;
   logic        JOY_LOAD;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic        frame_stb;
   logic        changed;

   logic [31:0] raw   = '1;
   logic [31:0] chain = '1;

   int checks = 0;
   int errors = 0;

   logic [31:0] frames[$];

   always #5 clk = ~clk;

   db15_joy_scan #(.CLK_DIV(CD), .GAP_TICKS(GT)) dut (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .JOY_DATA  (JOY_DATA),
      .JOY_CLK   (JOY_CLK),
      .JOY_LOAD  (JOY_LOAD),
      .joystick1 (joystick1),
      .joystick2 (joystick2),
      .frame_stb (frame_stb),
      .changed   (changed)
   );

   // Adapter: parallel load while JOY_LOAD low, shift toward bit 0 on JOY_CLK rise.
   assign JOY_DATA = chain[0];
   always @(posedge JOY_CLK or negedge JOY_LOAD) begin
      if (!JOY_LOAD) chain <= raw;
      else           chain <= {1'b1, chain[31:1]};
   end

   // Reference: outputs show the newest value seen in two consecutive frames.
   function automatic logic [31:0] stable_value();
      for (int i = frames.size() - 1; i > 0; i--)
         if (frames[i] == frames[i-1]) return frames[i];
      return 32'h0;
   endfunction

   task automatic model_reset();
      frames = {};
      frames.push_back(32'h0);
   endtask

   task automatic model_frame(input logic [31:0] rawv, output logic [31:0] expv, output bit exp_chg);
      logic [31:0] old;
      old = stable_value();
      frames.push_back(~rawv);
      expv    = stable_value();
      exp_chg = (expv != old);
   endtask

   task automatic run_frame(output bit got, output bit chg, output int clks, output int stray);
      got = 0; chg = 0; clks = 0; stray = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         clks++;
         if (frame_stb) begin
            got = 1;
            chg = changed;
            break;
         end
         if (changed) stray++;
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      raw     = '1;
      repeat (3) @(negedge clk);
      model_reset();
      checks++;
      if ({JOY_CLK, JOY_LOAD, frame_stb, changed} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_ctrl clk/load/stb/chg=%b required=0100", {JOY_CLK, JOY_LOAD, frame_stb, changed});
      end
      checks++;
      if ({joystick2, joystick1} !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got=%h required=00000000", {joystick2, joystick1});
      end
   endtask

   task automatic test_waveform();
      int t = 0, load_fall = -1, load_low = 0, first_rise = -1, stb_t = -1;
      int rises = 0, bad_hi = 0, bad_lo = 0, viol = 0, hi_len = 0, lo_len = 0;
      bit prev_c = 0;
      logic [31:0] ev;
      bit ec;
      RESET_N = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         t++;
         if (!JOY_LOAD) begin
            load_low++;
            if (load_fall < 0) load_fall = t;
            if (JOY_CLK) viol++;
         end
         if (JOY_CLK && !prev_c) begin
            rises++;
            if (first_rise < 0) first_rise = t;
            else if (lo_len != CD) bad_lo++;
            hi_len = 1;
         end else if (JOY_CLK) begin
            hi_len++;
         end else if (prev_c) begin
            if (hi_len != CD) bad_hi++;
            lo_len = 1;
         end else begin
            lo_len++;
         end
         prev_c = JOY_CLK;
         if (frame_stb) begin
            stb_t = t;
            break;
         end
      end
      checks++;
      if (load_fall != GT * CD) begin
         errors++;
         $display("FAIL load_fall_time got=%0d required=%0d", load_fall, GT * CD);
      end
      checks++;
      if (load_low != 2 * CD) begin
         errors++;
         $display("FAIL load_low_width got=%0d required=%0d", load_low, 2 * CD);
      end
      checks++;
      if (first_rise != (GT + 4) * CD) begin
         errors++;
         $display("FAIL first_clk_rise got=%0d required=%0d", first_rise, (GT + 4) * CD);
      end
      checks++;
      if (rises != 32) begin
         errors++;
         $display("FAIL clk_rise_count got=%0d required=32", rises);
      end
      checks++;
      if (bad_hi != 0 || bad_lo != 0) begin
         errors++;
         $display("FAIL clk_pulse_shape bad_high=%0d bad_low=%0d required=0/0", bad_hi, bad_lo);
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL clk_during_load got=%0d required=0", viol);
      end
      checks++;
      if (stb_t != FRAME_CLKS) begin
         errors++;
         $display("FAIL first_frame_stb got=%0d required=%0d", stb_t, FRAME_CLKS);
      end
      model_frame(raw, ev, ec);
      checks++;
      if ({joystick2, joystick1} !== ev || changed !== ec) begin
         errors++;
         $display("FAIL first_frame_out got=%h/%b required=%h/%b", {joystick2, joystick1}, changed, ev, ec);
      end
   endtask

   task automatic test_idle();
      bit got, chg, ec;
      int clks, stray;
      logic [31:0] ev;
      raw = '1;
      for (int f = 0; f < 3; f++) begin
         run_frame(got, chg, clks, stray);
         model_frame(raw, ev, ec);
         checks++;
         if (!got || clks != FRAME_CLKS) begin
            errors++;
            $display("FAIL idle_period frame=%0d got=%0d required=%0d", f, got ? clks : -1, FRAME_CLKS);
         end
         checks++;
         if ({joystick2, joystick1} !== ev || chg !== 1'b0 || stray != 0) begin
            errors++;
            $display("FAIL idle_out frame=%0d got=%h chg=%b stray=%0d required=%h/0/0", f, {joystick2, joystick1}, chg, stray, ev);
         end
      end
   endtask

   task automatic test_p1_right();
      bit got, chg, ec;
      int clks, stray;
      logic [31:0] ev;
      raw = {16'hFFFF, 16'hFFFE};
      for (int f = 0; f < 2; f++) begin
         run_frame(got, chg, clks, stray);
         model_frame(raw, ev, ec);
         checks++;
         if (!got || {joystick2, joystick1} !== ev || chg !== ec || stray != 0) begin
            errors++;
            $display("FAIL p1_right frame=%0d got=%h chg=%b stb=%b required=%h/%b", f, {joystick2, joystick1}, chg, got, ev, ec);
         end
      end
      checks++;
      if (joystick1 !== 16'h0001 || joystick2 !== 16'h0000) begin
         errors++;
         $display("FAIL p1_right_value got=%h/%h required=0001/0000", joystick1, joystick2);
      end
   endtask

   task automatic test_p2_bits();
      bit got, chg, ec;
      int clks, stray;
      logic [31:0] ev;
      raw = {16'hF7DF, 16'hFFFF};
      for (int f = 0; f < 2; f++) begin
         run_frame(got, chg, clks, stray);
         model_frame(raw, ev, ec);
         checks++;
         if (!got || {joystick2, joystick1} !== ev || chg !== ec || stray != 0) begin
            errors++;
            $display("FAIL p2_bits frame=%0d got=%h chg=%b stb=%b required=%h/%b", f, {joystick2, joystick1}, chg, got, ev, ec);
         end
      end
      checks++;
      if (joystick2 !== 16'h0820 || joystick1 !== 16'h0000) begin
         errors++;
         $display("FAIL p2_bits_value got=%h/%h required=0820/0000", joystick2, joystick1);
      end
   endtask

   task automatic test_glitch();
      bit got, chg, ec;
      int clks, stray;
      int chg_seen = 0;
      logic [31:0] ev;
      logic [31:0] seq[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      for (int f = 0; f < 5; f++) begin
         raw = seq[f];
         run_frame(got, chg, clks, stray);
         model_frame(raw, ev, ec);
         if (f >= 2 && (chg || stray != 0)) chg_seen++;
         checks++;
         if (!got || {joystick2, joystick1} !== ev || chg !== ec || stray != 0) begin
            errors++;
            $display("FAIL glitch frame=%0d got=%h chg=%b stb=%b required=%h/%b", f, {joystick2, joystick1}, chg, got, ev, ec);
         end
      end
      checks++;
      if (chg_seen != 0 || {joystick2, joystick1} !== 32'h0) begin
         errors++;
         $display("FAIL glitch_filtered changes=%0d out=%h required=0/00000000", chg_seen, {joystick2, joystick1});
      end
   endtask

   task automatic test_random();
      bit got, chg, ec;
      int clks, stray;
      logic [31:0] ev;
      for (int f = 0; f < 12; f++) begin
         if ($urandom_range(0, 1) == 0) raw = $urandom;
         run_frame(got, chg, clks, stray);
         model_frame(raw, ev, ec);
         checks++;
         if (!got || {joystick2, joystick1} !== ev || chg !== ec || stray != 0) begin
            errors++;
            $display("FAIL random frame=%0d raw=%h got=%h chg=%b stb=%b required=%h/%b", f, raw, {joystick2, joystick1}, chg, got, ev, ec);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit got, chg, ec;
      int clks, stray, rises = 0;
      bit prev_c = 0, reached = 0;
      logic [31:0] ev, x, y;
      x = $urandom & ~32'h0000_0100;
      y = $urandom & ~32'h0001_0000;
      raw = x;
      for (int f = 0; f < 2; f++) begin
         run_frame(got, chg, clks, stray);
         model_frame(raw, ev, ec);
      end
      checks++;
      if ({joystick2, joystick1} !== ~x) begin
         errors++;
         $display("FAIL pre_reset_out got=%h required=%h", {joystick2, joystick1}, ~x);
      end
      raw = y;
      for (int i = 0; i < 600 && !reached; i++) begin
         @(negedge clk);
         if (JOY_CLK && !prev_c) rises++;
         prev_c = JOY_CLK;
         if (rises == 17) reached = 1;
      end
      @(negedge clk);
      RESET_N = 1'b0;
      #1;
      checks++;
      if (!reached || {JOY_CLK, JOY_LOAD, frame_stb, changed} !== 4'b0100 || {joystick2, joystick1} !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset reached=%b ctrl=%b out=%h required=1/0100/00000000", reached, {JOY_CLK, JOY_LOAD, frame_stb, changed}, {joystick2, joystick1});
      end
      repeat (3) @(negedge clk);
      model_reset();
      RESET_N = 1'b1;
      for (int f = 0; f < 2; f++) begin
         run_frame(got, chg, clks, stray);
         model_frame(raw, ev, ec);
         checks++;
         if (!got || {joystick2, joystick1} !== ev || chg !== ec || stray != 0) begin
            errors++;
            $display("FAIL post_reset frame=%0d got=%h chg=%b stb=%b required=%h/%b", f, {joystick2, joystick1}, chg, got, ev, ec);
         end
      end
      checks++;
      if ({joystick2, joystick1} !== ~y) begin
         errors++;
         $display("FAIL post_reset_value got=%h required=%h", {joystick2, joystick1}, ~y);
      end
   endtask

   initial begin
      RESET_N = 1'b1;
      #3;
      test_reset();
      test_waveform();
      test_idle();
      test_p1_right();
      test_p2_bits();
      test_glitch();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
